// File: rtl/arb_pkg.sv
// Shared types and helpers for the 4-way round-robin arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // First set request found when scanning ptr, ptr+1, ... modulo NUM_REQ.
    // The 2-bit add wraps naturally, so no explicit modulo is needed.
    // Returns ptr when no request is set; callers only use it when |req.
    function automatic logic [IDX_W-1:0] next_rr_winner(
        input logic [NUM_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr
    );
        logic [IDX_W-1:0] win;
        logic [IDX_W-1:0] cand;
        logic             found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/decoder2to4.sv
// Library 2-to-4 decoder: one-hot of a when enabled.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: a (2-bit select), e (enable), y (4-bit output).
// Note: with e=0 the output is 1000, not 0000; users must mask.
module decoder2to4 (
    input  logic [1:0] a,
    input  logic       e,
    output logic [3:0] y
);

    always_comb begin
        y = 4'b1000;
        if (e) begin
            y = 4'b0001 << a;
        end
    end

endmodule

// File: rtl/rr_arb4_ctrl.sv
// Round-robin arbiter sharing one resource among 4 requesters, with hold limit.
// Latency: req sampled in cycle n gives gnt in cycle n+1; release seen one cycle after req drops.
// Backpressure: none; requesters hold req high until granted, non-owner req ignored during a grant.
// Ports: clk, rst_n (sync, active-low), req[3:0] in; gnt[3:0] one-hot,
//        gnt_idx[1:0], gnt_valid, timeout (one-cycle pulse on forced release) out.
module rr_arb4_ctrl
    import arb_pkg::*;
#(
    parameter  int MAX_HOLD = 8,
    localparam int CNT_W    = $clog2(MAX_HOLD)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid,
    output logic               timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q,    state_d;
    logic [IDX_W-1:0] ptr_q,      ptr_d;
    logic [IDX_W-1:0] gnt_idx_q,  gnt_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q,  timeout_d;
    logic [NUM_REQ-1:0] dec_y;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Next-state logic. ptr moves only on release, so each owner passes
    // priority to its successor and nobody can be starved.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d    = GRANT;
                    gnt_idx_d  = next_rr_winner(req, ptr_q);
                    hold_cnt_d = '0;
                end
            end
            GRANT: begin
                // Voluntary release takes precedence over the hold limit,
                // so a drop on the last allowed cycle is not a timeout.
                if (!req[gnt_idx_q]) begin
                    state_d    = IDLE;
                    ptr_d      = gnt_idx_q + 1'b1;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = IDLE;
                    ptr_d      = gnt_idx_q + 1'b1;
                    hold_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs come from registers only; no req-to-gnt combinational path.
    assign gnt_valid = (state_q == GRANT);
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;

    decoder2to4 u_dec (
        .a (gnt_idx_q),
        .e (gnt_valid),
        .y (dec_y)
    );

    // The decoder idles at 1000, so the mask is what makes gnt zero when idle.
    always_comb begin
        gnt = dec_y & {NUM_REQ{gnt_valid}};
    end

endmodule

// File: doc/rr_arb4_ctrl.md
Name: rr_arb4_ctrl

Overview:
- Round-robin arbiter and controller that shares one resource among 4 requesters.
- Selects a winner, holds the grant until release or hold-limit timeout, then rotates priority.
- Winner index drives the library decoder2to4 to produce the one-hot grant bus.
- Sits between requesting agents and the shared resource's select/enable logic.

Parameters:
- MAX_HOLD, default 8: maximum consecutive grant cycles per owner. Legal range 2..255.
- CNT_W, default $clog2(MAX_HOLD): hold-counter width. Derived; do not override.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- req  in  4  request per requester; held high while the resource is wanted.
- gnt  out  4  one-hot grant; 0000 when no owner.
- gnt_idx  out  2  registered index of the current owner.
- gnt_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked at MAX_HOLD.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, ptr=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, timeout=0, gnt=0000. Reset overrides all other events, including mid-grant.
- States: IDLE, GRANT.
- IDLE with req==0000: remain in IDLE; outputs stay 0.
- IDLE with req!=0000:
  - Winner = first set req bit scanning ptr, ptr+1, ... mod 4.
  - Next edge: GRANT, gnt_idx=winner, gnt_valid=1, hold_cnt=0.
  - Latency: req sampled in cycle n gives gnt in cycle n+1.
- GRANT, each cycle:
  - req[gnt_idx]==0 (voluntary release): next edge IDLE, gnt_valid=0, ptr=gnt_idx+1 mod 4, timeout=0.
  - Else if hold_cnt==MAX_HOLD-1: same transition, and timeout=1 for exactly the following cycle.
  - Else: hold_cnt+1, grant unchanged.
  - A grant is therefore visible for at most MAX_HOLD cycles.
- Voluntary release and the hold limit in the same cycle: treat as voluntary; timeout=0.
- Grant deasserts one cycle after the owner's req drops.
- At least one IDLE cycle separates consecutive grants; no back-to-back handover.
- Non-owner req changes during GRANT are ignored until IDLE.
- ptr wraps 3->0.
- ptr is updated only on release, so repeated rearbitration cannot starve any requester. Worst-case wait is 3*(MAX_HOLD+1) cycles.
- gnt = decoder2to4(A=gnt_idx, E=gnt_valid) AND {4{gnt_valid}}.
  - Masking is mandatory: decoder2to4 drives 1000 when E=0.
  - gnt is combinational from registers only; there is no path from req to gnt.
- timeout is registered and zero in every cycle except the IDLE cycle after a forced release.
- hold_cnt never exceeds MAX_HOLD-1; no wrap.

Decomposition:
- Shared package arb_pkg:
  - NUM_REQ=4, IDX_W=2.
  - State enum arb_state_t {IDLE, GRANT}.
  - Function next_rr_winner(req, ptr) returning the 2-bit index.
- Sub-module: reuse the existing decoder2to4 for the one-hot grant. No other sub-module.

Test Plan:
1. Reset: rst_n=0 for 3 cycles with req=1111 -> gnt=0000, gnt_valid=0, timeout=0. After rst_n=1, first grant is 0001 (ptr=0).
2. Voluntary release: req=0100 in cycles 0-2, 0000 from cycle 3 -> gnt=0100, gnt_idx=2 in cycles 1-3; gnt=0000 in cycle 4; timeout never asserted; ptr becomes 3.
3. Rotation and timeout, MAX_HOLD=4, req=1111 held -> grants 0001, 0010, 0100, 1000, 0001.
   - Each grant lasts 4 cycles, separated by 1 IDLE cycle.
   - timeout=1 in each IDLE gap.
4. Wrap: complete a grant to requester 3 (ptr=0), then grant to 1 (ptr=2), then req=0011 -> scan 2,3,0 gives gnt=0001; after release, req=0011 gives gnt=0010.
5. Simultaneous events, MAX_HOLD=4: owner drops req exactly in its 4th grant cycle -> IDLE next cycle, timeout=0. Separately, rst_n=0 during cycle 2 of a grant -> next cycle gnt=0000, gnt_valid=0, ptr=0.
6. Isolation: during a grant to 0001, toggle req[3:1] every cycle -> gnt stays 0001, gnt_idx stays 0 until release or timeout; gnt is never multi-hot and never 1000 while gnt_valid=0.
